pcie_link_status_monitor: RTL

//  Parametrised PCIe link health monitor and status-LED driver in the user_clk domain.
//  - Debounces user_lnk_up into link_stable.
//  - Checks negotiated width and speed against expected values.
//  - Counts link-down events and drives 4 board LEDs: link, heartbeat, width, speed.
//  - Sits in the top level beside the PCIe wrapper; software reads the stats outputs via the status register block.

---
 rtl/pcie_link_status_if.sv | 23 ++
 rtl/pcie_link_status_monitor.sv | 91 +++++++++
 2 files changed

// File: rtl/pcie_link_status_if.sv
// pcie_link_status_if: PCIe core status inputs and link-health outputs of the link status monitor
interface pcie_link_status_if #(
  parameter int FLAP_CNT_WIDTH = 16
);
  logic                      user_lnk_up;
  logic [2:0]                cfg_current_speed;
  logic [3:0]                cfg_negotiated_width;
  logic                      clr_stats;
  logic                      link_stable;
  logic                      lane_width_error;
  logic                      link_speed_error;
  logic                      link_down_sticky;
  logic [FLAP_CNT_WIDTH-1:0] link_down_count;
  logic [3:0]                led;
  modport master (
    output user_lnk_up, cfg_current_speed, cfg_negotiated_width, clr_stats,
    input  link_stable, lane_width_error, link_speed_error, link_down_sticky, link_down_count, led
  );
  modport slave (
    input  user_lnk_up, cfg_current_speed, cfg_negotiated_width, clr_stats,
    output link_stable, lane_width_error, link_speed_error, link_down_sticky, link_down_count, led
  );
endinterface

// File: rtl/pcie_link_status_monitor.sv
// pcie_link_status_monitor: debounced PCIe link health, flap statistics and status LEDs; LINK_MON_FLAP_CNT_EN enables link_down_count
module pcie_link_status_monitor #(
  parameter int LED_CTR_WIDTH   = 26,
  parameter int EXP_LINK_WIDTH  = 8,
  parameter int EXP_LINK_SPEED  = 4,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int FLAP_CNT_WIDTH  = 16
) (
  input logic               user_clk,
  input logic               perst_n,
  pcie_link_status_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {DOWN, TRAIN, UP} state_t;
  state_t                   state, state_nx;
  logic [DW-1:0]            deb_cnt, deb_nx;
  logic [LED_CTR_WIDTH-1:0] led_ctr;
  logic                     width_err, speed_err, sticky, drop;
  // link state and debounce counter registers
  always_ff @(posedge user_clk or negedge perst_n) begin
    if (!perst_n) begin
      state   <= DOWN;
      deb_cnt <= '0;
    end else begin
      state   <= state_nx;
      deb_cnt <= deb_nx;
    end
  end
  // debounce FSM: a drop is only an UP->DOWN transition, never an aborted training
  always_comb begin
    state_nx = state;
    deb_nx   = deb_cnt;
    drop     = 1'b0;
    case (state)
      DOWN: if (bus.user_lnk_up) begin
        state_nx = TRAIN;
        deb_nx   = DW'(1);
      end
      TRAIN: if (!bus.user_lnk_up) begin
        state_nx = DOWN;
        deb_nx   = '0;
      end else if (deb_cnt == DW'(DEBOUNCE_CYCLES)) begin
        state_nx = UP;
        deb_nx   = '0;
      end else begin
        deb_nx = deb_cnt + DW'(1);
      end
      UP: if (!bus.user_lnk_up) begin
        state_nx = DOWN;
        drop     = 1'b1;
      end
      default: begin
        state_nx = DOWN;
        deb_nx   = '0;
      end
    endcase
  end
  // free-running heartbeat, error flags gated by the link state they will coexist with, and drop sticky bit
  always_ff @(posedge user_clk or negedge perst_n) begin
    if (!perst_n) begin
      led_ctr   <= '0;
      width_err <= 1'b0;
      speed_err <= 1'b0;
      sticky    <= 1'b0;
    end else begin
      led_ctr   <= led_ctr + LED_CTR_WIDTH'(1);
      width_err <= (state_nx == UP) && (bus.cfg_negotiated_width != 4'(EXP_LINK_WIDTH));
      speed_err <= (state_nx == UP) && (bus.cfg_current_speed != 3'(EXP_LINK_SPEED));
      sticky    <= drop | (sticky & ~bus.clr_stats);
    end
  end
`ifdef LINK_MON_FLAP_CNT_EN
  logic [FLAP_CNT_WIDTH-1:0] flap_cnt;
  // saturating drop counter; a drop coinciding with a clear leaves a count of one
  always_ff @(posedge user_clk or negedge perst_n) begin
    if (!perst_n) flap_cnt <= '0;
    else flap_cnt <= bus.clr_stats ? FLAP_CNT_WIDTH'(drop) : (drop && !(&flap_cnt)) ? flap_cnt + FLAP_CNT_WIDTH'(1) : flap_cnt;
  end
  assign bus.link_down_count = flap_cnt;
`else
  assign bus.link_down_count = '0;
`endif
  assign bus.link_stable      = (state == UP);
  assign bus.lane_width_error = width_err;
  assign bus.link_speed_error = speed_err;
  assign bus.link_down_sticky = sticky;
  assign bus.led[0] = bus.link_stable & ~(sticky & led_ctr[LED_CTR_WIDTH-3]);
  assign bus.led[1] = led_ctr[LED_CTR_WIDTH-1];
  assign bus.led[2] = width_err ? led_ctr[LED_CTR_WIDTH-2] : bus.link_stable;
  assign bus.led[3] = speed_err ? led_ctr[LED_CTR_WIDTH-2] : bus.link_stable;
endmodule
